// File: rtl/dx_stage_ctrl.sv
// ---------------------------------------------------------------------------
// dx_stage_ctrl
//
// Decode/execute pipeline register and hazard controller. It sits directly
// downstream of the opcode decoder and holds the X-stage copy of the
// instruction, its PC+1 and the eight decoded control bits.
//
// It does three things:
//   - inserts a bubble into X on a load-use hazard (1-cycle penalty),
//   - inserts a bubble into X when a taken branch/jump is flushed,
//   - sequences the multi-cycle multdiv unit (start pulse, then stall the
//     front end until the unit reports its result ready).
//
// Ports
//   clock           in   rising-edge system clock
//   reset           in   asynchronous, active-high reset
//   fd_insn[31:0]   in   instruction currently in F/D
//   fd_pc[31:0]     in   PC+1 of fd_insn
//   fd_ctrl[7:0]    in   {Rwe,br,DMwe,ALUinB,Rwd,j_sig,jr_sig,jal_sig}
//   flush           in   taken branch/jump resolved in X; squash fd_insn
//   data_resultRDY  in   multdiv done
//   data_exception  in   multdiv exception, valid with data_resultRDY
//   dx_insn[31:0]   out  X-stage instruction
//   dx_pc[31:0]     out  X-stage PC+1
//   dx_ctrl[7:0]    out  X-stage control bundle (same order as fd_ctrl)
//   stall_fd        out  hold PC and F/D register
//   ctrl_MULT       out  one-cycle multdiv start, multiply
//   ctrl_DIV        out  one-cycle multdiv start, divide
//   md_exc          out  last mul/div raised an exception
//   stall_cycles    out  count of stalled clock edges
//
// Build option
//   DX_STALL_COUNT_EN  when defined, stall_cycles counts every clock edge
//                      with stall_fd=1 (wrapping); otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module dx_stage_ctrl #(
    parameter logic [31:0] NOP_INSN = 32'h0000_0000,
    parameter logic [4:0]  MUL_OP   = 5'b00110,
    parameter logic [4:0]  DIV_OP   = 5'b00111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] fd_pc,
    input  logic [7:0]  fd_ctrl,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    output logic [31:0] dx_insn,
    output logic [31:0] dx_pc,
    output logic [7:0]  dx_ctrl,
    output logic        stall_fd,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        md_exc,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } md_state_t;

    // What the X register does on the coming edge.
    typedef enum logic [1:0] {
        X_HOLD,
        X_BUBBLE,
        X_LOAD
    } x_sel_t;

    localparam int CTRL_RWD = 3;  // Rwd bit position: set only for lw

    md_state_t state, next_state;
    x_sel_t    x_sel;

    // ---------------- instruction field decode ----------------
    logic [4:0] fd_opcode, fd_rd, fd_rs, fd_rt, fd_aluop;
    logic [4:0] dx_opcode, dx_rd, dx_aluop;

    assign fd_opcode = fd_insn[31:27];
    assign fd_rd     = fd_insn[26:22];
    assign fd_rs     = fd_insn[21:17];
    assign fd_rt     = fd_insn[16:12];
    assign fd_aluop  = fd_insn[6:2];
    assign dx_opcode = dx_insn[31:27];
    assign dx_rd     = dx_insn[26:22];
    assign dx_aluop  = dx_insn[6:2];

    logic fd_is_r, fd_reads_rd, fd_is_md;
    logic dx_is_mul, dx_is_div;
    logic load_use, md_hold;

    assign fd_is_r = (fd_opcode == 5'b00000);

    // sw, bne, jr and blt read the register named in the rd field.
    assign fd_reads_rd = (fd_opcode == 5'b00111) || (fd_opcode == 5'b00010) ||
                         (fd_opcode == 5'b00100) || (fd_opcode == 5'b00110);

    assign fd_is_md  = fd_is_r && ((fd_aluop == MUL_OP) || (fd_aluop == DIV_OP));
    assign dx_is_mul = (dx_opcode == 5'b00000) && (dx_aluop == MUL_OP);
    assign dx_is_div = (dx_opcode == 5'b00000) && (dx_aluop == DIV_OP);

    // A lw in X writing a non-zero register that F/D is about to read.
    assign load_use = dx_ctrl[CTRL_RWD] && (dx_rd != 5'd0) &&
                      ((dx_rd == fd_rs) ||
                       (fd_is_r && (dx_rd == fd_rt)) ||
                       (fd_reads_rd && (dx_rd == fd_rd)));

    // X holds a mul/div whose result is not yet available.
    assign md_hold = (state == S_START) || ((state == S_WAIT) && !data_resultRDY);

    // ---------------- next-state / output logic ----------------
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        x_sel      = X_LOAD;
        stall_fd   = 1'b0;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;

        // X register source, in priority order. A held mul/div cannot have
        // produced a flush, so flush is ignored while holding.
        if (md_hold) begin
            x_sel    = X_HOLD;
            stall_fd = 1'b1;
        end else if (flush) begin
            x_sel = X_BUBBLE;
        end else if (load_use) begin
            x_sel    = X_BUBBLE;
            stall_fd = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (x_sel == X_LOAD && fd_is_md) next_state = S_START;
            end
            S_START: begin
                ctrl_MULT  = dx_is_mul;
                ctrl_DIV   = dx_is_div;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                // A mul/div following directly behind restarts the unit
                // rather than passing through IDLE.
                if (data_resultRDY)
                    next_state = (x_sel == X_LOAD && fd_is_md) ? S_START : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ---------------- state and X-stage registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dx_insn <= NOP_INSN;
            dx_pc   <= 32'h0;
            dx_ctrl <= 8'h00;
        end else begin
            case (x_sel)
                X_LOAD: begin
                    dx_insn <= fd_insn;
                    dx_pc   <= fd_pc;
                    dx_ctrl <= fd_ctrl;
                end
                X_BUBBLE: begin
                    // Control forced to zero: the decoder asserts Rwe for
                    // opcode 00000, so the NOP word alone is not harmless.
                    dx_insn <= NOP_INSN;
                    dx_pc   <= fd_pc;
                    dx_ctrl <= 8'h00;
                end
                default: ;  // hold
            endcase
        end
    end

    // Exception flag: captured when the unit reports ready, then kept until
    // X next advances onto something that is not a mul/div.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_exc <= 1'b0;
        end else if (state == S_WAIT && data_resultRDY) begin
            md_exc <= data_exception;
        end else if (x_sel == X_BUBBLE || (x_sel == X_LOAD && !fd_is_md)) begin
            md_exc <= 1'b0;
        end
    end

    // ---------------- optional stall counter ----------------
`ifdef DX_STALL_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'h0;
        end else if (stall_fd) begin
            stall_cycles <= stall_cycles + 32'd1;  // wraps naturally
        end
    end
`else
    assign stall_cycles = 32'h0;
`endif

    // Instruction bits this block has no use for.
    logic unused_bits;
    assign unused_bits = &{1'b0, fd_insn[11:7], fd_insn[1:0],
                           dx_insn[21:7], dx_insn[1:0]};

endmodule
